// File: rtl/pp_input_cond.sv
// pp_input_cond: two-channel synchronise + debounce front end for the PP_6
// sequence detector. Each channel has a 2-flop synchroniser followed by a
// STABLE/PENDING debounce FSM. A new synchronised level is accepted once it
// has been seen on DEB_CYCLES consecutive cycles. The block also produces a
// registered one-cycle chg pulse whenever the clean a and/or b level changes.
// Optional build macro: PP_COND_EDGE_EN adds registered a_rise/b_rise pulses.

// One debounce channel. out_o is the registered clean level; upd_o is
// combinational and flags that out_o takes a new value at the next edge.
module pp_cond_chan #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic Clk,
    input  logic Rst,
    input  logic raw_i,
    output logic out_o,
    output logic upd_o
);
    typedef enum logic {STABLE, PENDING} state_t;

    localparam logic [CNT_W-1:0] DEB_C = CNT_W'(DEB_CYCLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             s1_q, s2_q;
    logic             out_q, out_d;

    // cnt_q holds how many consecutive differing samples have been seen so
    // far, so the sample that brings the count to DEB_CYCLES is the one that
    // updates the output. It therefore never exceeds DEB_CYCLES-1 and cannot
    // wrap.
    assign cnt_inc = cnt_q + 1'b1;

    // Synchroniser, FSM state, counter and clean output registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Debounce next-state logic: qualify a differing s2 level for DEB_CYCLES
    // consecutive samples; any return to the current level cancels it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (s2_q != out_q) begin
                    if (DEB_CYCLES == 1) begin
                        out_d = s2_q;
                    end else begin
                        state_d = PENDING;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            PENDING: begin
                if (s2_q == out_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_inc == DEB_C) begin
                    out_d   = s2_q;
                    cnt_d   = '0;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out_o = out_q;
    assign upd_o = (out_d != out_q);
endmodule

// Top: two identical channels (index 0 = A, 1 = B) plus change flags.
module pp_input_cond #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3
) (
    input  logic Clk,
    input  logic Rst,
    input  logic a_raw,
    input  logic b_raw,
    output logic a,
    output logic b,
`ifdef PP_COND_EDGE_EN
    output logic a_rise,
    output logic b_rise,
`endif
    output logic chg
);
    logic [1:0] raw, out, upd;
    logic       chg_q, chg_d;

    assign raw = {b_raw, a_raw};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        pp_cond_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_chan (
            .Clk   (Clk),
            .Rst   (Rst),
            .raw_i (raw[i]),
            .out_o (out[i]),
            .upd_o (upd[i])
        );
    end

    // chg is registered on the same edge that updates a/b, so it is high
    // during the first cycle the new level is visible; a simultaneous A and
    // B update still yields a single pulse.
    assign chg_d = |upd;

    // Change-flag register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) chg_q <= 1'b0;
        else      chg_q <= chg_d;
    end

    assign a   = out[0];
    assign b   = out[1];
    assign chg = chg_q;

`ifdef PP_COND_EDGE_EN
    logic [1:0] rise_q, rise_d;

    // A rising edge is an update while the current clean level is 0.
    assign rise_d = upd & ~out;

    // Rising-edge flag registers, aligned with chg.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) rise_q <= 2'b00;
        else      rise_q <= rise_d;
    end

    assign a_rise = rise_q[0];
    assign b_rise = rise_q[1];
`endif
endmodule
